// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-controller bus between the pipeline (master) and the controller (slave)
interface pipeline_hazard_ctrl_if;
    logic [11:0] id_opcode;
    logic [4:0]  id_rs1_ind;
    logic [4:0]  id_rs2_ind;
    logic [4:0]  ex_rd_ind;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        imem_ready;
    logic        pc_write;
    logic        if_id_write;
    logic        if_flush;
    logic        id_ex_bubble;
    logic [1:0]  state;
    modport master (
        output id_opcode, id_rs1_ind, id_rs2_ind, ex_rd_ind, ex_mem_read, ex_branch_taken, imem_ready,
        input  pc_write, if_id_write, if_flush, id_ex_bubble, state
    );
    modport slave (
        input  id_opcode, id_rs1_ind, id_rs2_ind, ex_rd_ind, ex_mem_read, ex_branch_taken, imem_ready,
        output pc_write, if_id_write, if_flush, id_ex_bubble, state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch redirect and fetch-miss control FSM; HAZARD_PERF_CNT_EN adds stall/flush counters
module pipeline_hazard_ctrl (
    input  logic                       clk,
    input  logic                       rst,
    pipeline_hazard_ctrl_if.slave      bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]                stall_cnt,
    output logic [15:0]                flush_cnt
`endif
);
    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] LU_STALL   = 2'd1;
    localparam logic [1:0] FLUSH      = 2'd2;
    localparam logic [1:0] FETCH_WAIT = 2'd3;

    logic [1:0] st;
    logic [1:0] nxt;
    logic       lu;
    logic       redirect;
    logic       stall;
    logic       miss;

    // hazard classification: redirect and load-use only matter in RUN/FETCH_WAIT, the bubble in EX masks them elsewhere
    always_comb begin
        lu       = bus.ex_mem_read && (bus.ex_rd_ind != 5'd0) &&
                   (bus.ex_rd_ind == bus.id_rs1_ind || bus.ex_rd_ind == bus.id_rs2_ind);
        redirect = (st == RUN || st == FETCH_WAIT) && bus.ex_branch_taken;
        stall    = (st == RUN || st == FETCH_WAIT) && !bus.ex_branch_taken && lu;
        miss     = !redirect && !stall && !bus.imem_ready;
        nxt      = redirect ? FLUSH : stall ? LU_STALL : miss ? FETCH_WAIT : RUN;
    end

    // pipeline controls; reset forces a frozen front end with a bubble into EX
    always_comb begin
        bus.pc_write     = rst && !stall && !miss;
        bus.if_id_write  = rst && !stall;
        bus.if_flush     = rst && (redirect || miss);
        bus.id_ex_bubble = !rst || redirect || stall;
        bus.state        = st;
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= RUN;
        else      st <= nxt;
    end

`ifdef HAZARD_PERF_CNT_EN
    // saturating counts of frozen-PC cycles and redirect cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!bus.pc_write && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (redirect && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed-vector bench for pipeline_hazard_ctrl (HAZARD_PERF_CNT_EN enables counter checks)
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst;
    int   passed;
    int   total;
    logic [5:0] obs;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    // observed vector: {pc_write, if_id_write, if_flush, id_ex_bubble, state}
    assign obs = {bus.pc_write, bus.if_id_write, bus.if_flush, bus.id_ex_bubble, bus.state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // input vector: {ex_mem_read, ex_branch_taken, imem_ready, ex_rd_ind, id_rs1_ind, id_rs2_ind}
    localparam logic [17:0] IDLE  = {3'b001, 5'd0, 5'd0, 5'd0};
    localparam logic [17:0] MISS  = {3'b000, 5'd0, 5'd0, 5'd0};
    localparam logic [17:0] LU2   = {3'b101, 5'd5, 5'd0, 5'd5};
    localparam logic [17:0] LU1   = {3'b101, 5'd7, 5'd7, 5'd3};
    localparam logic [17:0] LU1M  = {3'b100, 5'd7, 5'd7, 5'd3};
    localparam logic [17:0] NOLD  = {3'b001, 5'd7, 5'd7, 5'd3};
    localparam logic [17:0] RD0   = {3'b101, 5'd0, 5'd0, 5'd0};
    localparam logic [17:0] BR_LU = {3'b110, 5'd5, 5'd0, 5'd5};
    localparam logic [17:0] BR_LR = {3'b111, 5'd5, 5'd0, 5'd5};
    localparam logic [17:0] BR_M  = {3'b010, 5'd0, 5'd0, 5'd0};

    task automatic apply(input logic [17:0] v);
        {bus.ex_mem_read, bus.ex_branch_taken, bus.imem_ready,
         bus.ex_rd_ind, bus.id_rs1_ind, bus.id_rs2_ind} = v;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        apply(IDLE);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        apply(BR_LR);
        #3;
        total++;
        if (obs !== 6'b000100) $display("FAIL reset_hold got %b want %b", obs, 6'b000100);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (obs !== 6'b000100) $display("FAIL reset_edge got %b want %b", obs, 6'b000100);
        else passed++;
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        else passed++;
`endif
        apply(IDLE);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 6'b110000) $display("FAIL reset_release got %b want %b", obs, 6'b110000);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        logic [17:0] in_v [0:6];
        logic [5:0]  exp_v [0:6];
        in_v  = '{LU2, LU2, IDLE, LU1, LU1M, IDLE, NOLD};
        exp_v = '{6'b000100, 6'b110001, 6'b110000, 6'b000100, 6'b011001, 6'b110011, 6'b110000};
        for (int i = 0; i < 7; i++) begin
            apply(in_v[i]);
            @(negedge clk);
            total++;
            if (obs !== exp_v[i]) $display("FAIL load_use[%0d] got %b want %b", i, obs, exp_v[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rd_zero();
        for (int i = 0; i < 2; i++) begin
            apply(RD0);
            @(negedge clk);
            total++;
            if (obs !== 6'b110000) $display("FAIL rd_zero[%0d] got %b want %b", i, obs, 6'b110000);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        logic [17:0] in_v [0:10];
        logic [5:0]  exp_v [0:10];
        do_reset();
        in_v  = '{BR_LU, BR_LR, IDLE, BR_M, MISS, IDLE, IDLE, MISS, BR_M, BR_LR, IDLE};
        exp_v = '{6'b111100, 6'b110010, 6'b110000, 6'b111100, 6'b011010, 6'b110011,
                  6'b110000, 6'b011000, 6'b111111, 6'b110010, 6'b110000};
        for (int i = 0; i < 11; i++) begin
            apply(in_v[i]);
            @(negedge clk);
            total++;
            if (obs !== exp_v[i]) $display("FAIL redirect[%0d] got %b want %b", i, obs, exp_v[i]);
            else passed++;
            @(posedge clk); #1;
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (flush_cnt !== 16'd3 || stall_cnt !== 16'd2) $display("FAIL redirect_cnt got %0d/%0d want 3/2", flush_cnt, stall_cnt);
        else passed++;
`endif
    endtask

    task automatic test_fetch_miss();
        logic [17:0] in_v [0:4];
        logic [5:0]  exp_v [0:4];
        do_reset();
        in_v  = '{MISS, MISS, MISS, IDLE, IDLE};
        exp_v = '{6'b011000, 6'b011011, 6'b011011, 6'b110011, 6'b110000};
        for (int i = 0; i < 5; i++) begin
            apply(in_v[i]);
            @(negedge clk);
            total++;
            if (obs !== exp_v[i]) $display("FAIL fetch_miss[%0d] got %b want %b", i, obs, exp_v[i]);
            else passed++;
            @(posedge clk); #1;
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (stall_cnt !== 16'd3 || flush_cnt !== 16'd0) $display("FAIL fetch_miss_cnt got %0d/%0d want 3/0", stall_cnt, flush_cnt);
        else passed++;
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        apply(LU2);
        @(posedge clk); #1;
        total++;
        if (obs !== 6'b110001) $display("FAIL async_pre got %b want %b", obs, 6'b110001);
        else passed++;
        #2 rst = 1'b0;
        #1;
        total++;
        if (obs !== 6'b000100) $display("FAIL async_assert got %b want %b", obs, 6'b000100);
        else passed++;
        apply(IDLE);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 6'b110000) $display("FAIL async_release got %b want %b", obs, 6'b110000);
        else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (obs !== 6'b110000) $display("FAIL async_after got %b want %b", obs, 6'b110000);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        passed = 0;
        total  = 0;
        bus.id_opcode = 12'h023;
        apply(IDLE);
        test_reset();
        test_load_use();
        test_rd_zero();
        test_redirect();
        test_fetch_miss();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous reset, active-low (0 = reset asserted).
REQ-003 SHALL have port: id_opcode  input  12  decoded opcode of the instruction in ID: {inst[31:26], funct if R-format else 0}.
REQ-004 SHALL have ports: id_rs1_ind, id_rs2_ind  input  5 each  ID-stage source register indices.
REQ-005 SHALL have port: ex_rd_ind  input  5  destination register index of the instruction in EX.
REQ-006 SHALL have port: ex_mem_read  input  1  EX-stage instruction is a load.
REQ-007 SHALL have port: ex_branch_taken  input  1  branch/jump resolved taken in EX; PC redirect required.
REQ-008 SHALL have port: imem_ready  input  1  instruction memory returns valid fetch data this cycle.
REQ-009 SHALL have ports: pc_write, if_id_write, if_flush, id_ex_bubble  output  1 each  PC enable, IF/ID buffer write enable, IF/ID flush, zero-control injection into ID/EX.
REQ-010 SHALL have port: state  output  2  current FSM state encoding.

Function
REQ-011 SHALL implement FSM states RUN=2'd0, LU_STALL=2'd1, FLUSH=2'd2, FETCH_WAIT=2'd3; state register only sequential element besides REQ-024 counters.
REQ-012 SHALL compute outputs combinationally from current state and inputs (zero-cycle latency to the pipeline).
REQ-013 SHALL define load-use hazard LU = ex_mem_read & (ex_rd_ind != 0) & (ex_rd_ind == id_rs1_ind | ex_rd_ind == id_rs2_ind).
REQ-014 SHALL define "normal" outputs: pc_write=1, if_id_write=1, if_flush=0, id_ex_bubble=0.
REQ-015 SHALL give priority in RUN and FETCH_WAIT: ex_branch_taken > LU > !imem_ready > normal.
REQ-016 Redirect (ex_branch_taken=1): pc_write=1, if_id_write=1, if_flush=1, id_ex_bubble=1; next state FLUSH.
REQ-017 LU in RUN: pc_write=0, if_id_write=0, if_flush=0, id_ex_bubble=1; next LU_STALL.
REQ-018 Fetch miss (!imem_ready): pc_write=0, if_id_write=1, if_flush=1, id_ex_bubble=0; next FETCH_WAIT.
REQ-019 LU_STALL: ignore LU and ex_branch_taken (EX holds bubble); if imem_ready, normal outputs and next RUN; else fetch-miss outputs and next FETCH_WAIT.
REQ-020 FLUSH (exactly one cycle): ignore ex_branch_taken and LU; imem_ready -> normal, next RUN; else fetch-miss, next FETCH_WAIT.
REQ-021 FETCH_WAIT: remain with fetch-miss outputs while imem_ready=0; on imem_ready=1 normal outputs, next RUN; redirect per REQ-016 overrides.
REQ-022 SHALL never assert if_flush while if_id_write=0.

Reset
REQ-023 While rst=0: state=RUN, pc_write=0, if_id_write=0, if_flush=0, id_ex_bubble=1, counters 0; first active edge after deassertion evaluates RUN normally; reset mid-stall abandons the stall.

Configuration
REQ-024 Macro HAZARD_PERF_CNT_EN defined: adds outputs stall_cnt[15:0] (+1 each cycle pc_write=0, rst high) and flush_cnt[15:0] (+1 each redirect cycle), both saturating at 16'hFFFF.
REQ-025 Macro undefined: those ports and counters absent; all other behaviour identical.

Verification
REQ-026 ex_mem_read=1, ex_rd_ind=5, id_rs2_ind=5, imem_ready=1 in RUN -> one cycle pc_write=0/if_id_write=0/id_ex_bubble=1, state 1, then normal, state 0.
REQ-027 Same as REQ-026 but ex_rd_ind=0 -> no stall, outputs normal, state stays 0.
REQ-028 ex_branch_taken=1 together with LU and imem_ready=0 -> redirect outputs (1,1,1,1), state 2; next cycle ex_branch_taken=1 ignored.
REQ-029 imem_ready=0 for 3 cycles from RUN -> 3 cycles pc_write=0/if_flush=1, state 3, then normal, state 0; with HAZARD_PERF_CNT_EN stall_cnt=3.
REQ-030 rst driven 0 asynchronously mid LU_STALL -> outputs immediately to REQ-023 values without clock edge; after release state 0.
